// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Power-up and recovery sequencer for the system PLL. It pulses the PLL
//   reset, then waits for lock with a timeout. Lock must then hold for a
//   qualification window before the system reset is released. A lock loss
//   during RUN restarts the sequence. After a bounded number of failed lock
//   attempts the block parks in FAIL.
//   The whole block runs on the free-running reference clock.
//
// Ports
//   refclk          free-running reference clock
//   rst             asynchronous, active-high reset
//   pll_locked      PLL lock indication, asynchronous to refclk
//   soft_reset_req  single-cycle request to restart the sequence
//   pll_rst         PLL reset, active-high
//   sys_rst         downstream system reset, active-high; low only in RUN
//   ready           high only in RUN
//   fail            high only in FAIL
//   retry_cnt       retries consumed in the current sequence
//   lock_lost_stb   one-cycle pulse on a lock loss in RUN
//   lock_loss_cnt   saturating count of lock-loss events
//
// Build option
//   PLL_SEQ_LOCK_LOSS_CNT_EN : when defined, lock_loss_cnt counts lock-loss
//   events. It saturates at 0xFFFF and is cleared only by rst. When the macro
//   is undefined the port is tied to 0.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 24000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        soft_reset_req,
    output logic        pll_rst,
    output logic        sys_rst,
    output logic        ready,
    output logic        fail,
    output logic [3:0]  retry_cnt,
    output logic        lock_lost_stb,
    output logic [15:0] lock_loss_cnt
);

    localparam longint CYC_MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                   longint'(RST_PULSE_CYCLES) : longint'(LOCK_STABLE_CYCLES);
    localparam longint CYC_MAX   = (longint'(LOCK_TIMEOUT_CYCLES) > CYC_MAX_A) ?
                                   longint'(LOCK_TIMEOUT_CYCLES) : CYC_MAX_A;

    generate
        if (RST_PULSE_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_cycles
            $error("pll_lock_sequencer: cycle parameters must be >= 1");
        end
        if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retries
            $error("pll_lock_sequencer: MAX_RETRIES must be 0..15");
        end
        if (CNT_W < 1 || CNT_W > 62 || CYC_MAX >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
            $error("pll_lock_sequencer: CNT_W too narrow for the cycle parameters");
        end
    endgenerate

    // The counter compares against the last cycle of each window.
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             stb_nxt;
    logic [1:0]       sync;
    logic             locked_s;

    // Two-flop synchronizer for the asynchronous lock signal.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[0], pll_locked};
    end
    assign locked_s = sync[1];

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        stb_nxt   = 1'b0;
        // Only the timed states count. RUN and FAIL park the counter at 0.
        cnt_nxt   = (state inside {RESET_PLL, WAIT_LOCK, STABLE}) ? cnt + 1'b1 : '0;

        if (soft_reset_req) begin
            // Soft reset outranks everything, including a lock loss in RUN.
            state_nxt = RESET_PLL;
            retry_nxt = '0;
        end else begin
            case (state)
                RESET_PLL: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TMO_LAST) begin
                        if (retry_cnt == MAX_R) begin
                            state_nxt = FAIL;
                        end else begin
                            retry_nxt = retry_cnt + 4'd1;
                            state_nxt = RESET_PLL;
                        end
                    end
                end
                // A lock glitch falls back to WAIT_LOCK without spending a retry.
                STABLE: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        stb_nxt   = 1'b1;
                        state_nxt = RESET_PLL;
                    end
                end
                FAIL:    state_nxt = FAIL;
                default: state_nxt = RESET_PLL;
            endcase
        end

        // Every transition, and every soft reset, restarts the counter.
        if (state_nxt != state || soft_reset_req) cnt_nxt = '0;
    end

    // The outputs are decoded from the next state. They change on the same
    // edge as the state they reflect.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= '0;
            lock_lost_stb <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pll_rst       <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
            sys_rst       <= (state_nxt != RUN);
            ready         <= (state_nxt == RUN);
            fail          <= (state_nxt == FAIL);
            retry_cnt     <= retry_nxt;
            lock_lost_stb <= stb_nxt;
        end
    end

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    // The count steps on the same edge as lock_lost_stb. Soft reset does not clear it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)                                   lock_loss_cnt <= '0;
        else if (stb_nxt && lock_loss_cnt != '1)   lock_loss_cnt <= lock_loss_cnt + 16'd1;
    end
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        soft_reset_req = 1'b0;
    logic        pll_rst, sys_rst, ready, fail, lock_lost_stb;
    logic [3:0]  retry_cnt;
    logic [15:0] lock_loss_cnt;

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    localparam int LL = 1;
`else
    localparam int LL = 0;
`endif

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .CNT_W               (16)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .fail           (fail),
        .retry_cnt      (retry_cnt),
        .lock_lost_stb  (lock_lost_stb),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    // Free-running edge counter. It is not touched by rst.
    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    // Expected value layout: {pll_rst, sys_rst, ready, fail, retry_cnt, lock_lost_stb, lock_loss_cnt}.
    typedef struct {
        int          cyc;
        string       name;
        logic [24:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int at, input string nm, input bit p, input bit s, input bit r,
                        input bit f, input int rc, input bit st, input int llc);
        exp_t e;
        e.cyc  = at;
        e.name = nm;
        e.v    = {p, s, r, f, 4'(rc), st, 16'(llc)};
        sb.push_back(e);
    endtask

    // Stop 1 time unit after edge n, when the inputs are safe to drive.
    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Monitor: on each falling edge, compare every expectation due at this cycle.
    initial begin
        exp_t        e;
        logic [24:0] act;
        forever begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e   = sb.pop_front();
                act = {pll_rst, sys_rst, ready, fail, retry_cnt, lock_lost_stb, lock_loss_cnt};
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: due at cycle %0d, sampled at %0d", e.name, e.cyc, cyc);
                end else if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s @%0d: got pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d stb=%b llc=%0d, want pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d stb=%b llc=%0d",
                             e.name, cyc, act[24], act[23], act[22], act[21], act[20:17], act[16], act[15:0],
                             e.v[24], e.v[23], e.v[22], e.v[21], e.v[20:17], e.v[16], e.v[15:0]);
                end
            end
        end
    end

    initial begin
        int b, c, d, dd, e, f;

        // Clean power-up: rst released just after edge b, so edge b+1 is the first live edge.
        b = 3;
        go_to(b);
        rst = 1'b0;
        push(b,      "reset_vals",   1, 1, 0, 0, 0, 0, 0);
        push(b + 3,  "pulse_hi",     1, 1, 0, 0, 0, 0, 0);
        push(b + 4,  "pulse_fall",   0, 1, 0, 0, 0, 0, 0);
        push(b + 11, "wait_sync",    0, 1, 0, 0, 0, 0, 0);
        push(b + 19, "stable_pre",   0, 1, 0, 0, 0, 0, 0);
        push(b + 20, "run",          0, 0, 1, 0, 0, 0, 0);
        go_to(b + 9);
        pll_locked = 1'b1;

        // Lock loss in RUN: the drop is sampled at b+26, so the strobe comes at b+28.
        go_to(b + 25);
        push(b + 27, "run_still",    0, 0, 1, 0, 0, 0, 0);
        push(b + 28, "lock_lost",    1, 1, 0, 0, 0, 1, LL);
        push(b + 29, "stb_end",      1, 1, 0, 0, 0, 0, LL);
        push(b + 31, "re_pulse_hi",  1, 1, 0, 0, 0, 0, LL);
        push(b + 32, "re_pulse_fall",0, 1, 0, 0, 0, 0, LL);
        push(b + 44, "re_stable",    0, 1, 0, 0, 0, 0, LL);
        push(b + 45, "re_run",       0, 0, 1, 0, 0, 0, LL);
        pll_locked = 1'b0;
        go_to(b + 34);
        pll_locked = 1'b1;

        // Soft reset from RUN, then a one-cycle lock glitch in STABLE.
        c = b + 50;
        go_to(c);
        push(c + 1,  "soft_in_run",  1, 1, 0, 0, 0, 0, LL);
        push(c + 5,  "soft_wait",    0, 1, 0, 0, 0, 0, LL);
        push(c + 14, "glitch_noearly",0, 1, 0, 0, 0, 0, LL);
        push(c + 20, "glitch_pre",   0, 1, 0, 0, 0, 0, LL);
        push(c + 21, "glitch_run",   0, 0, 1, 0, 0, 0, LL);
        soft_reset_req = 1'b1;
        go_to(c + 1);
        soft_reset_req = 1'b0;
        go_to(c + 9);
        pll_locked = 1'b0;
        go_to(c + 10);
        pll_locked = 1'b1;

        // Lock loss and soft reset together (soft wins), then lock never returns.
        d  = c + 30;
        dd = d + 3;
        go_to(d);
        push(d + 2,   "pre_collide",  0, 0, 1, 0, 0, 0, LL);
        push(dd,      "soft_wins",    1, 1, 0, 0, 0, 0, LL);
        push(dd + 1,  "no_stb",       1, 1, 0, 0, 0, 0, LL);
        push(dd + 3,  "nl_pulse_hi",  1, 1, 0, 0, 0, 0, LL);
        push(dd + 4,  "nl_pulse_fall",0, 1, 0, 0, 0, 0, LL);
        push(dd + 35, "tmo1_pre",     0, 1, 0, 0, 0, 0, LL);
        push(dd + 36, "tmo1",         1, 1, 0, 0, 1, 0, LL);
        push(dd + 39, "retry1_pulse", 1, 1, 0, 0, 1, 0, LL);
        push(dd + 40, "retry1_wait",  0, 1, 0, 0, 1, 0, LL);
        push(dd + 71, "tmo2_pre",     0, 1, 0, 0, 1, 0, LL);
        push(dd + 72, "tmo2",         1, 1, 0, 0, 2, 0, LL);
        push(dd + 76, "retry2_wait",  0, 1, 0, 0, 2, 0, LL);
        push(dd + 107,"fail_pre",     0, 1, 0, 0, 2, 0, LL);
        push(dd + 108,"fail_enter",   1, 1, 0, 1, 2, 0, LL);
        push(dd + 118,"fail_hold",    1, 1, 0, 1, 2, 0, LL);
        pll_locked = 1'b0;
        go_to(d + 2);
        soft_reset_req = 1'b1;
        go_to(d + 3);
        soft_reset_req = 1'b0;

        // Soft reset out of FAIL, normal lock reaches RUN.
        e = dd + 120;
        go_to(e);
        push(e + 1,  "soft_in_fail", 1, 1, 0, 0, 0, 0, LL);
        push(e + 13, "sf_stable",    0, 1, 0, 0, 0, 0, LL);
        push(e + 14, "sf_run",       0, 0, 1, 0, 0, 0, LL);
        soft_reset_req = 1'b1;
        go_to(e + 1);
        soft_reset_req = 1'b0;
        pll_locked = 1'b1;

        // Async reset between edges while in STABLE.
        f = e + 20;
        go_to(f);
        push(f + 7,  "mid_stable",   0, 1, 0, 0, 0, 0, LL);
        push(f + 8,  "async_rst",    1, 1, 0, 0, 0, 0, 0);
        push(f + 15, "post_rst_wait",0, 1, 0, 0, 0, 0, 0);
        soft_reset_req = 1'b1;
        go_to(f + 1);
        soft_reset_req = 1'b0;
        go_to(f + 8);
        #1;
        rst = 1'b1;
        go_to(f + 11);
        rst = 1'b0;

        go_to(f + 25);
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations never sampled, want 0", sb.size());
            errors = errors + sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
